mult_accumulator: RTL

//  Downstream consumer of array_multiplier: accepts 4-bit operand pairs over a valid/ready

---
 rtl/mult_accumulator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - multiply-accumulate stage summing N_TERMS 4x4 products per result
//
// Purpose
//   Accepts unsigned 4-bit operand pairs on a valid/ready handshake, multiplies each pair
//   in an array_multiplier, and sums N_TERMS products into an ACC_W-bit accumulator. The
//   finished sum is held on a result handshake until the sink takes it.
//
// Configuration macro
//   SATURATE_EN : when defined, the accumulator clamps to all-ones on carry-out;
//                 when undefined, it wraps modulo 2**ACC_W. overflow is flagged either way.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   clear      in   1      synchronous abort of the partial sum and any held result
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      pair can be accepted (ACCUM state)
//   a, b       in   4      unsigned multiplicand / multiplier
//   out_valid  out  1      result valid (registered)
//   out_ready  in   1      sink accepts the result
//   acc_out    out  ACC_W  accumulated sum (registered)
//   term_cnt   out  CNT_W  pairs accepted in the current window
//   overflow   out  1      sticky carry-out flag for the current window

module array_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);
    // One shifted partial-product row per multiplier bit, summed down the array.
    always_comb begin
        product = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                product = product + ({4'b0000, a} << i);
            end
        end
    end
endmodule

module mult_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             overflow
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [ACC_W-1:0]   acc_out_next;
    logic               out_valid_next;
    logic               overflow_next;

    logic [7:0]         product;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   add_val;
    logic               last_term;

    array_multiplier u_mul (
        .a       (a),
        .b       (b),
        .product (product)
    );

    // One extra bit on the adder exposes the carry-out used for the overflow flag.
    assign sum   = {1'b0, acc} + {1'b0, ACC_W'(product)};
    assign carry = sum[ACC_W];

`ifdef SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the clamp persists.
    assign add_val = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign add_val = sum[ACC_W-1:0];
`endif

    assign last_term = (term_cnt == CNT_W'(N_TERMS - 1));
    assign in_ready  = (state == ACCUM);

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = term_cnt;
        acc_out_next   = acc_out;
        out_valid_next = out_valid;
        overflow_next  = overflow;
        case (state)
            ACCUM: begin
                if (in_valid) begin
                    overflow_next = overflow | carry;
                    if (last_term) begin
                        acc_out_next   = add_val;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next = add_val;
                        cnt_next = term_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    overflow_next  = 1'b0;
                    state_next     = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // clear behaves exactly like rst, including dropping a held result.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= ACCUM;
            acc       <= '0;
            term_cnt  <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            term_cnt  <= cnt_next;
            acc_out   <= acc_out_next;
            out_valid <= out_valid_next;
            overflow  <= overflow_next;
        end
    end
endmodule
